// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes follow the EX-stage funct decode; states are the sequencer's.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`define MD_CNT_W(w) ($clog2((w) + 1))

package muldiv_unit_pkg;
   localparam logic [1:0] MD_OP_MULT  = 2'b00;
   localparam logic [1:0] MD_OP_MULTU = 2'b01;
   localparam logic [1:0] MD_OP_DIV   = 2'b10;
   localparam logic [1:0] MD_OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;
endpackage

// File: rtl/muldiv_fixup.sv
// Sign / zero-divisor correction from raw magnitude result to final HI/LO.
// Latency: purely combinational, zero cycles.
// Backpressure: none; consumed by the sequencer in its FIX cycle.
module muldiv_fixup #(
   parameter int WORD_WIDTH = 32
) (
   input  logic                      is_div,
   input  logic                      neg_res,
   input  logic                      neg_rem,
   input  logic                      div_zero,
   input  logic [2*WORD_WIDTH-1:0]   raw,
   input  logic [WORD_WIDTH-1:0]     a_raw,
   output logic [WORD_WIDTH-1:0]     hi,
   output logic [WORD_WIDTH-1:0]     lo
);
   localparam int W = WORD_WIDTH;

   logic [2*W-1:0] prod;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;

   always_comb begin
      prod = neg_res ? (~raw + 1'b1) : raw;
      quo  = neg_res ? (~raw[W-1:0] + 1'b1) : raw[W-1:0];
      rem  = neg_rem ? (~raw[2*W-1:W] + 1'b1) : raw[2*W-1:W];
      hi   = prod[2*W-1:W];
      lo   = prod[W-1:0];
      if (is_div) begin
         // Zero divisor: no trap, HI returns the untouched dividend.
         if (div_zero) begin
            hi = a_raw;
            lo = '1;
         end else begin
            hi = rem;
            lo = quo;
         end
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes.
// Latency: WORD_WIDTH+1 cycles from start to done pulse with HI/LO updated.
// Backpressure: busy stalls HI/LO consumers; start and strobes ignored while busy.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WORD_WIDTH = `WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [WORD_WIDTH-1:0] src_a,
   input  logic [WORD_WIDTH-1:0] src_b,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] hi_out,
   output logic [WORD_WIDTH-1:0] lo_out,
   output logic                  busy,
   output logic                  done
);
   localparam int W  = WORD_WIDTH;
   localparam int CW = `MD_CNT_W(WORD_WIDTH);

   md_state_t      state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] acc, acc_step;
   logic [W-1:0]   opnd, a_raw, hi, lo, fix_hi, fix_lo;
   logic           is_div, neg_res, neg_rem, div_zero;
   logic           last_iter;

   logic           a_neg, b_neg;
   logic [W-1:0]   a_abs, b_abs;
   logic [W:0]     mul_sum;
   logic [W:0]     rem_ext;
   logic [W-1:0]   rem_sub;
   logic           rem_ge;

   assign last_iter = (cnt == CW'(W - 1));
   assign busy      = (state != MD_IDLE);
   assign hi_out    = hi;
   assign lo_out    = lo;

   always_comb begin
      a_neg = ~op[0] & src_a[W-1];
      b_neg = ~op[0] & src_b[W-1];
      a_abs = a_neg ? (~src_a + 1'b1) : src_a;
      b_abs = b_neg ? (~src_b + 1'b1) : src_b;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (start) state_nxt = MD_RUN;
         MD_RUN:  if (last_iter) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
   // Divide:   acc = {partial remainder, dividend bits / quotient bits}, shift left.
   always_comb begin
      mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      rem_ext = acc[2*W-1:W-1];
      rem_ge  = (rem_ext >= {1'b0, opnd});
      rem_sub = rem_ext[W-1:0] - opnd;
      if (is_div)
         acc_step = rem_ge ? {rem_sub, acc[W-2:0], 1'b1}
                           : {rem_ext[W-1:0], acc[W-2:0], 1'b0};
      else
         acc_step = {mul_sum, acc[W-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         a_raw    <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= (src_b == '0);
                  a_raw    <= src_a;
                  cnt      <= '0;
                  if (op[1]) begin
                     acc  <= {{W{1'b0}}, a_abs};
                     opnd <= b_abs;
                  end else begin
                     acc  <= {{W{1'b0}}, b_abs};
                     opnd <= a_abs;
                  end
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            MD_RUN: begin
               acc <= acc_step;
               cnt <= cnt + CW'(1);
            end
            MD_FIX: begin
               hi   <= fix_hi;
               lo   <= fix_lo;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   muldiv_fixup #(.WORD_WIDTH(W)) u_fixup (
      .is_div   (is_div),
      .neg_res  (neg_res),
      .neg_rem  (neg_rem),
      .div_zero (div_zero),
      .raw      (acc),
      .a_raw    (a_raw),
      .hi       (fix_hi),
      .lo       (fix_lo)
   );
endmodule
